// File: rtl/pixel_frame_loader.sv
// rtl/pixel_frame_loader.sv - HPS pixel PIO to on-chip image RAM frame loader
//
// Purpose:
//   Accepts one pixel at a time from the HPS over a toggle handshake, packs it
//   into its sub-word slot of the RAM word, writes the image RAM, tracks the
//   row/column position in the frame and reports ack/done/busy/error status.
//
// Ports:
//   clk_clk                    system clock
//   reset_reset                synchronous, active-high reset
//   pixel_data_export          pixel value from the HPS PIO
//   pixel_status_write_export  [0] request toggle, [1] frame start level, [3:2] reserved
//   pixel_row_export           current row index (zero-extended)
//   pixel_status_read_export   [0] ack toggle, [1] frame done, [2] busy, [3] sticky error
//   image_ram_address          RAM word address
//   image_ram_clken/chipselect/write  RAM strobes, asserted together for one cycle
//   image_ram_writedata        pixel shifted into its slot
//   image_ram_byteenable       byte lanes of the written slot
//
// Optional feature:
//   PIXEL_SYNC_EN  when defined, status_write[1:0] goes through a 2-flop
//                  synchroniser before edge/toggle detection (handshake
//                  latency 4 cycles instead of 2).
module pixel_frame_loader #(
  parameter int PIX_W  = 24,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 18,
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [PIX_W-1:0]    pixel_data_export,
  input  logic [3:0]          pixel_status_write_export,
  output logic [15:0]         pixel_row_export,
  output logic [3:0]          pixel_status_read_export,
  output logic [ADDR_W-1:0]   image_ram_address,
  output logic                image_ram_clken,
  output logic                image_ram_chipselect,
  output logic                image_ram_write,
  output logic [DATA_W-1:0]   image_ram_writedata,
  output logic [DATA_W/8-1:0] image_ram_byteenable
);

  localparam int PPW    = DATA_W / PIX_W;
  localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int BE_W   = DATA_W / 8;
  localparam int PIX_B  = PIX_W / 8;
  // Byte lanes of slot 0; 24-bit pixels give 4'b0111.
  localparam logic [BE_W-1:0] BE_BASE = BE_W'((64'd1 << PIX_B) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_REQ,
    S_WRITE,
    S_ACK,
    S_DONE
  } state_t;

  // Control inputs as seen by the detectors.
  logic [1:0] w_ctl;

`ifdef PIXEL_SYNC_EN
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= pixel_status_write_export[1:0];
      r_sync2 <= r_sync1;
    end
  end

  assign w_ctl = r_sync2;
`else
  assign w_ctl = pixel_status_write_export[1:0];
`endif

  // Reserved control bits are accepted but carry no function.
  logic w_unused_rsvd;
  assign w_unused_rsvd = ^pixel_status_write_export[3:2];

  state_t              r_state;
  logic                r_req_seen;
  logic                r_start_prev;
  logic                r_ack;
  logic                r_done;
  logic                r_busy;
  logic                r_error;
  logic                r_err_ack_pend;
  logic [15:0]         r_col;
  logic [15:0]         r_row;
  logic [SLOT_W-1:0]   r_slot;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;

  logic                w_start_rise;
  logic                w_req_pend;
  logic                w_slot_last;
  logic                w_col_last;
  logic                w_row_last;
  logic [31:0]         w_slot_off;
  logic [DATA_W-1:0]   w_pix_word;
  logic [BE_W-1:0]     w_pix_be;

  assign w_start_rise = w_ctl[1] & ~r_start_prev;
  assign w_req_pend   = w_ctl[0] ^ r_req_seen;
  assign w_slot_last  = (r_slot == SLOT_W'(PPW - 1));
  assign w_col_last   = (r_col == 16'(IMG_W - 1));
  assign w_row_last   = (r_row == 16'(IMG_H - 1));
  assign w_slot_off   = 32'(r_slot) * 32'(PIX_W);
  assign w_pix_word   = DATA_W'(pixel_data_export) << w_slot_off;
  assign w_pix_be     = BE_BASE << (w_slot_off >> 3);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state        <= S_IDLE;
      r_req_seen     <= 1'b0;
      r_start_prev   <= 1'b0;
      r_ack          <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
      r_error        <= 1'b0;
      r_err_ack_pend <= 1'b0;
      r_col          <= 16'd0;
      r_row          <= 16'd0;
      r_slot         <= '0;
      r_addr         <= '0;
      r_wr           <= 1'b0;
      r_wdata        <= '0;
      r_be           <= '0;
    end else begin
      r_start_prev <= w_ctl[1];
      r_wr         <= 1'b0;

      // A stray request absorbed in IDLE/DONE is still acked one cycle later
      // so the HPS never waits forever; a frame start does not cancel this.
      if (r_err_ack_pend) begin
        r_ack          <= ~r_ack;
        r_err_ack_pend <= 1'b0;
      end

      if (w_start_rise) begin
        // Frame start wins over everything, including a request arriving in
        // the same cycle, which stays pending for WAIT_REQ.
        r_state <= S_WAIT_REQ;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        r_error <= 1'b0;
        r_col   <= 16'd0;
        r_row   <= 16'd0;
        r_slot  <= '0;
        r_addr  <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (w_req_pend) begin
              r_req_seen     <= w_ctl[0];
              r_error        <= 1'b1;
              r_err_ack_pend <= 1'b1;
            end
          end

          S_WAIT_REQ: begin
            if (w_req_pend) begin
              r_req_seen <= w_ctl[0];
              r_wdata    <= w_pix_word;
              r_be       <= w_pix_be;
              r_wr       <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_WRITE;
            end
          end

          S_WRITE: begin
            r_state <= S_ACK;
          end

          S_ACK: begin
            r_ack  <= ~r_ack;
            r_busy <= 1'b0;
            if (w_col_last) begin
              // Row end always moves to a fresh word so rows start aligned.
              r_col  <= 16'd0;
              r_slot <= '0;
              r_addr <= r_addr + ADDR_W'(1);
              if (w_row_last) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_row   <= r_row + 16'd1;
                r_state <= S_WAIT_REQ;
              end
            end else begin
              r_col   <= r_col + 16'd1;
              r_state <= S_WAIT_REQ;
              if (w_slot_last) begin
                r_slot <= '0;
                r_addr <= r_addr + ADDR_W'(1);
              end else begin
                r_slot <= r_slot + SLOT_W'(1);
              end
            end
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign pixel_row_export         = r_row;
  assign pixel_status_read_export = {r_error, r_busy, r_done, r_ack};
  assign image_ram_address        = r_addr;
  assign image_ram_clken          = r_wr;
  assign image_ram_chipselect     = r_wr;
  assign image_ram_write          = r_wr;
  assign image_ram_writedata      = r_wdata;
  assign image_ram_byteenable     = r_be;

endmodule

// File: tb/tb_pixel_frame_loader.sv
// tb/tb_pixel_frame_loader.sv - self-checking bench for pixel_frame_loader
`timescale 1ns/1ps
module tb_pixel_frame_loader;

  localparam int AW = 8;
`ifdef PIXEL_SYNC_EN
  localparam int HS_LAT  = 5;  // negedges from driving a toggle to seeing the ack
  localparam int ERR_LAT = 4;
`else
  localparam int HS_LAT  = 3;
  localparam int ERR_LAT = 2;
`endif

  localparam int P0 = 16, W0 = 3, H0 = 2;
  localparam int P1 = 24, W1 = 2, H1 = 2;
  localparam int P2 = 8,  W2 = 5, H2 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]    sw [3];
  logic [P0-1:0] pd0;
  logic [P1-1:0] pd1;
  logic [P2-1:0] pd2;

  wire [3:0]    st0, st1, st2;
  wire [15:0]   row0, row1, row2;
  wire [AW-1:0] ad0, ad1, ad2;
  wire          ce0, cs0, we0, ce1, cs1, we1, ce2, cs2, we2;
  wire [31:0]   wd0, wd1, wd2;
  wire [3:0]    be0, be1, be2;

  pixel_frame_loader #(.PIX_W(P0), .DATA_W(32), .ADDR_W(AW), .IMG_W(W0), .IMG_H(H0)) u_dut0 (
    .clk_clk(clk), .reset_reset(rst), .pixel_data_export(pd0),
    .pixel_status_write_export(sw[0]), .pixel_row_export(row0),
    .pixel_status_read_export(st0), .image_ram_address(ad0),
    .image_ram_clken(ce0), .image_ram_chipselect(cs0), .image_ram_write(we0),
    .image_ram_writedata(wd0), .image_ram_byteenable(be0));

  pixel_frame_loader #(.PIX_W(P1), .DATA_W(32), .ADDR_W(AW), .IMG_W(W1), .IMG_H(H1)) u_dut1 (
    .clk_clk(clk), .reset_reset(rst), .pixel_data_export(pd1),
    .pixel_status_write_export(sw[1]), .pixel_row_export(row1),
    .pixel_status_read_export(st1), .image_ram_address(ad1),
    .image_ram_clken(ce1), .image_ram_chipselect(cs1), .image_ram_write(we1),
    .image_ram_writedata(wd1), .image_ram_byteenable(be1));

  pixel_frame_loader #(.PIX_W(P2), .DATA_W(32), .ADDR_W(AW), .IMG_W(W2), .IMG_H(H2)) u_dut2 (
    .clk_clk(clk), .reset_reset(rst), .pixel_data_export(pd2),
    .pixel_status_write_export(sw[2]), .pixel_row_export(row2),
    .pixel_status_read_export(st2), .image_ram_address(ad2),
    .image_ram_clken(ce2), .image_ram_chipselect(cs2), .image_ram_write(we2),
    .image_ram_writedata(wd2), .image_ram_byteenable(be2));

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } wr_t;

  typedef struct {
    int            d;
    logic [31:0]   pix;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
    logic [15:0]   row;
    logic          done;
  } vec_t;

  wr_t wq0 [$];
  wr_t wq1 [$];
  wr_t wq2 [$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Record every RAM write cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (ce0 | cs0 | we0) begin
      chk("strobes0", {ce0, cs0, we0}, {3{we0}});
      wq0.push_back('{ad0, wd0, be0});
    end
    if (ce1 | cs1 | we1) begin
      chk("strobes1", {ce1, cs1, we1}, {3{we1}});
      wq1.push_back('{ad1, wd1, be1});
    end
    if (ce2 | cs2 | we2) begin
      chk("strobes2", {ce2, cs2, we2}, {3{we2}});
      wq2.push_back('{ad2, wd2, be2});
    end
  end

  function automatic logic [3:0] get_st(input int d);
    case (d)
      0:       return st0;
      1:       return st1;
      default: return st2;
    endcase
  endfunction

  function automatic int wq_size(input int d);
    case (d)
      0:       return wq0.size();
      1:       return wq1.size();
      default: return wq2.size();
    endcase
  endfunction

  task automatic pop_wr(input int d, output wr_t w);
    case (d)
      0:       w = wq0.pop_front();
      1:       w = wq1.pop_front();
      default: w = wq2.pop_front();
    endcase
  endtask

  task automatic set_pd(input int d, input logic [31:0] pix);
    case (d)
      0:       pd0 = pix[P0-1:0];
      1:       pd1 = pix[P1-1:0];
      default: pd2 = pix[P2-1:0];
    endcase
  endtask

  // Reference placement: pixel k of a frame sits at row k/w, column k%w;
  // each row occupies ceil(w/ppw) words and starts on a fresh word.
  function automatic wr_t model_wr(input int pw, input int w, input int k, input logic [31:0] pix);
    int per = 32 / pw;
    int wpr = (w + per - 1) / per;
    int r = k / w;
    int c = k % w;
    int slot = c % per;
    logic [63:0] tmp;
    wr_t m;
    tmp = (64'(pix) & ((64'd1 << pw) - 64'd1)) << (slot * pw);
    m.addr = AW'(r * wpr + c / per);
    m.data = tmp[31:0];
    m.be   = 4'(((1 << (pw / 8)) - 1) << (slot * (pw / 8)));
    return m;
  endfunction

  function automatic int model_row(input int w, input int h, input int k);
    int r = (k + 1) / w;
    return (r < h) ? r : h - 1;
  endfunction

  task automatic do_pixel(input int d, input logic [31:0] pix, input bit with_start, input string nm);
    logic [3:0] st;
    logic a0;
    int lat;
    int nbusy;
    @(negedge clk);
    st = get_st(d);
    a0 = st[0];
    set_pd(d, pix);
    sw[d][0] = ~sw[d][0];
    if (with_start) sw[d][1] = 1'b1;
    lat = 0;
    nbusy = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      st = get_st(d);
      if (st[2]) nbusy++;
      if (st[0] != a0) lat = i;
    end
    chk({nm, "_lat"}, lat, with_start ? HS_LAT + 1 : HS_LAT);
    chk({nm, "_busy"}, nbusy, 2);
  endtask

  task automatic check_write(input int d, input wr_t e, input string nm);
    wr_t w;
    chk({nm, "_nwr"}, wq_size(d), 1);
    if (wq_size(d) > 0) begin
      pop_wr(d, w);
      chk({nm, "_addr"}, w.addr, e.addr);
      chk({nm, "_data"}, w.data, e.data);
      chk({nm, "_be"}, w.be, e.be);
    end
    while (wq_size(d) > 0) pop_wr(d, w);
  endtask

  task automatic start_frame(input int d);
    @(negedge clk);
    sw[d][1] = 1'b1;
    repeat (4) @(negedge clk);
    sw[d][1] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t tbl [10];
  logic [3:0]  st;
  logic        a0;
  logic [31:0] pix;
  int          lat;
  bit          seen;

  initial begin
    tbl[0] = '{1, 32'hABCDEF, 8'd0, 32'h00ABCDEF, 4'b0111, 16'd0, 1'b0};
    tbl[1] = '{1, 32'h123456, 8'd1, 32'h00123456, 4'b0111, 16'd1, 1'b0};
    tbl[2] = '{1, 32'h0F0F0F, 8'd2, 32'h000F0F0F, 4'b0111, 16'd1, 1'b0};
    tbl[3] = '{1, 32'hFFFFFF, 8'd3, 32'h00FFFFFF, 4'b0111, 16'd1, 1'b1};
    tbl[4] = '{0, 32'h1111,   8'd0, 32'h00001111, 4'b0011, 16'd0, 1'b0};
    tbl[5] = '{0, 32'h2222,   8'd0, 32'h22220000, 4'b1100, 16'd0, 1'b0};
    tbl[6] = '{0, 32'h3333,   8'd1, 32'h00003333, 4'b0011, 16'd1, 1'b0};
    tbl[7] = '{0, 32'h4444,   8'd2, 32'h00004444, 4'b0011, 16'd1, 1'b0};
    tbl[8] = '{0, 32'h5555,   8'd2, 32'h55550000, 4'b1100, 16'd1, 1'b0};
    tbl[9] = '{0, 32'h6666,   8'd3, 32'h00006666, 4'b0011, 16'd1, 1'b1};

    rst = 1'b1;
    for (int d = 0; d < 3; d++) sw[d] = 4'b0000;
    pd0 = '0;
    pd1 = '0;
    pd2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_st0", st0, 4'b0000);
    chk("rst_st1", st1, 4'b0000);
    chk("rst_st2", st2, 4'b0000);
    chk("rst_row0", row0, 16'd0);
    chk("rst_strobes0", {ce0, cs0, we0}, 3'b000);
    chk("rst_addr0", ad0, 8'd0);
    chk("rst_wdata0", wd0, 32'd0);
    chk("rst_be0", be0, 4'd0);
    rst = 1'b0;

    for (int d = 0; d < 3; d++) start_frame(d);
    chk("start_st0", st0, 4'b0000);
    chk("start_st1", st1, 4'b0000);
    chk("start_row0", row0, 16'd0);

    // Table vectors: 24-bit single-slot frame, then 16-bit two-slot frame.
    for (int i = 0; i < 10; i++) begin
      do_pixel(tbl[i].d, tbl[i].pix, 1'b0, $sformatf("tbl%0d", i));
      check_write(tbl[i].d, '{tbl[i].addr, tbl[i].data, tbl[i].be}, $sformatf("tbl%0d", i));
      st = get_st(tbl[i].d);
      chk($sformatf("tbl%0d_row", i), (tbl[i].d == 0) ? row0 : row1, tbl[i].row);
      chk($sformatf("tbl%0d_stat", i), st[3:1], {2'b00, tbl[i].done});
    end

    // Request in DONE: no write, sticky error, ack still toggles.
    @(negedge clk);
    st = st0;
    a0 = st[0];
    sw[0][0] = ~sw[0][0];
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(negedge clk);
      st = st0;
      if (st[0] != a0) lat = i;
    end
    chk("done_req_lat", lat, ERR_LAT);
    chk("done_req_stat", st0[3:1], 3'b101);
    chk("done_req_nwr", wq_size(0), 0);

    start_frame(0);
    chk("restart_stat", st0[3:1], 3'b000);
    chk("restart_row", row0, 16'd0);

    // Frame start during the write of pixel index 4.
    for (int k = 0; k < 4; k++) begin
      pix = 32'($urandom_range(0, 65535));
      do_pixel(0, pix, 1'b0, "pre_abort");
      check_write(0, model_wr(P0, W0, k, pix), "pre_abort");
    end
    @(negedge clk);
    set_pd(0, 32'h5555);
    sw[0][0] = ~sw[0][0];
    seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      if (we0) seen = 1'b1;
    end
    chk("abort_wr_seen", seen, 1'b1);
    sw[0][1] = 1'b1;
    repeat (8) @(negedge clk);
    sw[0][1] = 1'b0;
    repeat (2) @(negedge clk);
    check_write(0, model_wr(P0, W0, 4, 32'h5555), "abort_wr");
    chk("abort_row", row0, 16'd0);
    chk("abort_stat", st0[3:1], 3'b000);
    do_pixel(0, 32'h7777, 1'b0, "post_abort");
    check_write(0, model_wr(P0, W0, 0, 32'h7777), "post_abort");

    // Frame start and request in the same cycle on the finished 24-bit frame.
    do_pixel(1, 32'hC0FFEE, 1'b1, "start_req");
    sw[1][1] = 1'b0;
    check_write(1, model_wr(P1, W1, 0, 32'hC0FFEE), "start_req");
    chk("start_req_err", st1[3], 1'b0);

    // Randomised 8-bit frames, row width not a multiple of pixels per word.
    for (int f = 0; f < 2; f++) begin
      start_frame(2);
      for (int k = 0; k < W2 * H2; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        pix = $urandom;
        do_pixel(2, pix, 1'b0, "rnd");
        check_write(2, model_wr(P2, W2, k, pix), "rnd");
        chk("rnd_row", row2, 16'(model_row(W2, H2, k)));
        chk("rnd_done", st2[1], (k == W2 * H2 - 1));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
